// File: rtl/alu_result_queue.sv
// Result queue behind the 8-bit ALU: stores result/opcode with precomputed zero/carry flags.
// Latency: 1 cycle first-word fall-through (push at edge N is visible after edge N), no bypass.
// Backpressure: in_ready = !full from registered count only; out_* held while stalled.
// Optional build macro ALU_RESULT_QUEUE_STATS_EN adds a saturating accepted-push counter.
module alu_result_queue #(
  parameter int DEPTH = 4,
  parameter int RES_W = 16,
  parameter int SEL_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RES_W-1:0]         in_result,
  input  logic [SEL_W-1:0]         in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RES_W-1:0]         out_result,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_zero,
  output logic                     out_carry,
`ifdef ALU_RESULT_QUEUE_STATS_EN
  output logic [15:0]              stat_pushes,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = RES_W + SEL_W;

  // Payload and its flags live in separate arrays so the output path is pure readout.
  logic [PW-1:0]  pay_mem  [DEPTH];
  logic [1:0]     flag_mem [DEPTH];

  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count_q;

  logic           push;
  logic           pop;
  logic           in_zero;
  logic           in_carry;
  logic [PW-1:0]  head_pay;
  logic [1:0]     head_flag;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Flags are derived once at capture time; carry is only defined for add/sub/inc style ops.
  assign in_zero  = (in_result == '0);
  assign in_carry = in_result[8] &&
                    ((in_sel == SEL_W'(0)) || (in_sel == SEL_W'(1)) || (in_sel == SEL_W'(3)));

  assign head_pay  = pay_mem[rd_ptr];
  assign head_flag = flag_mem[rd_ptr];

  // Outputs are forced to zero while empty so stale RAM contents never leak out.
  assign out_result = out_valid ? head_pay[PW-1:SEL_W] : '0;
  assign out_sel    = out_valid ? head_pay[SEL_W-1:0]  : '0;
  assign out_zero   = out_valid && head_flag[1];
  assign out_carry  = out_valid && head_flag[0];

  // Pointer and occupancy update; flush discards any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage write; the RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pay_mem[wr_ptr]  <= {in_result, in_sel};
      flag_mem[wr_ptr] <= {in_zero, in_carry};
    end
  end

`ifdef ALU_RESULT_QUEUE_STATS_EN
  // Saturating count of accepted pushes since the last reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pushes <= '0;
    end else if (flush) begin
      stat_pushes <= '0;
    end else if (push && (stat_pushes != 16'hFFFF)) begin
      stat_pushes <= stat_pushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: reset, flags, stall, full, streaming, flush, async reset.
// Inputs change 1 time unit after each rising edge; outputs are sampled there as well.
// Build with ALU_RESULT_QUEUE_STATS_EN to also check the push counter.
module tb_alu_result_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_result = '0;
  logic [2:0]  in_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [2:0]  out_sel;
  logic        out_zero;
  logic        out_carry;
  logic [2:0]  count;
`ifdef ALU_RESULT_QUEUE_STATS_EN
  logic [15:0] stat_pushes;
`endif

  int vectors = 0;
  int errors  = 0;

  alu_result_queue #(.DEPTH(4), .RES_W(16), .SEL_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_zero   (out_zero),
    .out_carry  (out_carry),
`ifdef ALU_RESULT_QUEUE_STATS_EN
    .stat_pushes(stat_pushes),
`endif
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " count"},     32'(count), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready"},  32'(in_ready), 32'd1);
    chk({tag, " out_result"},32'(out_result), 32'd0);
    chk({tag, " out_sel"},   32'(out_sel), 32'd0);
    chk({tag, " out_zero"},  32'(out_zero), 32'd0);
    chk({tag, " out_carry"}, 32'(out_carry), 32'd0);
  endtask

  logic [15:0] exp_res;
  logic [2:0]  exp_sel;

  initial begin
    // Reset state
    #3;
    chk_empty("reset");
    tick();
    rst_n = 1'b1;

    // Zero result with sel=4: zero flag set, carry clear
    in_valid = 1'b1; in_result = 16'h0000; in_sel = 3'd4;
    tick();
    in_valid = 1'b0;
    chk("t1 out_valid", 32'(out_valid), 32'd1);
    chk("t1 out_zero",  32'(out_zero), 32'd1);
    chk("t1 out_carry", 32'(out_carry), 32'd0);
    chk("t1 out_sel",   32'(out_sel), 32'd4);
    chk("t1 count",     32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_empty("t1 drained");

    // Two pushes with the consumer stalled, then release
    in_valid = 1'b1; in_result = 16'h0100; in_sel = 3'd0;
    tick();
    in_result = 16'h00FF; in_sel = 3'd1;
    tick();
    in_valid = 1'b0;
    chk("t2 head",      32'(out_result), 32'h0100);
    chk("t2 carry",     32'(out_carry), 32'd1);
    chk("t2 zero",      32'(out_zero), 32'd0);
    chk("t2 count",     32'(count), 32'd2);
    tick();
    chk("t2 held head", 32'(out_result), 32'h0100);
    chk("t2 held sel",  32'(out_sel), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t2 next head", 32'(out_result), 32'h00FF);
    chk("t2 next sel",  32'(out_sel), 32'd1);
    chk("t2 next carry",32'(out_carry), 32'd0);
    chk("t2 next count",32'(count), 32'd1);
    tick();
    out_ready = 1'b0;
    chk("t2 drained",   32'(count), 32'd0);

    // Fill to DEPTH, offer a 5th push, pop one while full
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_result = 16'h1100 + 16'(i); in_sel = 3'(i);
      tick();
    end
    chk("t3 full count",    32'(count), 32'd4);
    chk("t3 full in_ready", 32'(in_ready), 32'd0);
    in_result = 16'hDEAD; in_sel = 3'd7;
    tick();
    chk("t3 5th ignored",   32'(count), 32'd4);
    chk("t3 head kept",     32'(out_result), 32'h1100);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t3 pop count",     32'(count), 32'd3);
    chk("t3 pop in_ready",  32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      // sel 0,1,3 take bit 8 as carry; sel 2 does not
      chk($sformatf("t3 drain res %0d", i),   32'(out_result), 32'h1100 + 32'(i));
      chk($sformatf("t3 drain sel %0d", i),   32'(out_sel), 32'(i));
      chk($sformatf("t3 drain carry %0d", i), 32'(out_carry), (i == 2) ? 32'd0 : 32'd1);
      tick();
    end
    out_ready = 1'b0;
    chk_empty("t3 drained");

    // Continuous stream of 10 entries; pointers wrap, occupancy stays at one
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_res   = 16'h2000 + 16'(i) * 16'h0101;
      exp_sel   = 3'(i % 8);
      in_result = exp_res; in_sel = exp_sel;
      tick();
      chk($sformatf("t4 res %0d", i),   32'(out_result), 32'(exp_res));
      chk($sformatf("t4 sel %0d", i),   32'(out_sel), 32'(exp_sel));
      chk($sformatf("t4 count %0d", i), 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("t4 drained", 32'(count), 32'd0);

    // Three entries queued, then flush with push and pop both active
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_result = 16'h3000 + 16'(i); in_sel = 3'd2;
      tick();
    end
    in_valid = 1'b0;
    chk("t5 count3", 32'(count), 32'd3);
`ifdef ALU_RESULT_QUEUE_STATS_EN
    chk("t5 stat before flush", 32'(stat_pushes), 32'd20);
`endif
    in_valid = 1'b1; in_result = 16'hBEEF; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_empty("t5 flushed");
`ifdef ALU_RESULT_QUEUE_STATS_EN
    chk("t5 stat flushed", 32'(stat_pushes), 32'd0);
`endif
    in_valid = 1'b1; in_result = 16'h4242; in_sel = 3'd5;
    tick();
    in_valid = 1'b0;
    chk("t5 post-flush head", 32'(out_result), 32'h4242);
    chk("t5 post-flush count", 32'(count), 32'd1);

    // Asynchronous reset in the middle of a cycle with data queued
    in_valid = 1'b1; in_result = 16'h0180; in_sel = 3'd3;
    tick();
    in_valid = 1'b0;
    chk("t6 pre-reset count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_empty("t6 async reset");
`ifdef ALU_RESULT_QUEUE_STATS_EN
    chk("t6 stat reset", 32'(stat_pushes), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("t6 after release", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
